multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1, meaning 1 = enter sticky ILLEGAL state on an unsupported opcode and 0 = treat it as a NOP and return to FETCH.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port instruction, input, 32 bits: instruction-register contents, valid from DECODE onward.
REQ-006 SHALL have port zero_flg, input, 1 bit: ALU zero result.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory has completed the current access this cycle.
REQ-008 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-009 SHALL have port AdrSrc, output, 1 bit: memory address select; 0 = PC, 1 = ALUOut.
REQ-010 SHALL have port IRWrite, output, 1 bit: load the instruction register.
REQ-011 SHALL have ports PCWrite, MemWrite and RegWrite, outputs, 1 bit each: write enables.
REQ-012 SHALL have port ResultSrc, output, 2 bits: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-013 SHALL have port ALUSrcA, output, 2 bits: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 SHALL have port ALUSrcB, output, 2 bits: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-015 SHALL have port ALUControl, output, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
REQ-016 SHALL have port ImmSrc, output, 2 bits: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 SHALL have ports instr_retired and halted, outputs, 1 bit each; state, output, 4 bits: debug view of the state register.

Function
REQ-018 SHALL implement a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ILLEGAL=11.
REQ-019 FETCH SHALL drive mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10, and drive IRWrite and PCWrite equal to mem_ready; it SHALL stay in FETCH while mem_ready=0.
REQ-020 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp add to form the branch target, then transition on opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other opcode -> ILLEGAL if HALT_ON_ILLEGAL=1, else FETCH.
REQ-021 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp add, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-022 MEMREAD SHALL drive mem_req=1, AdrSrc=1, ResultSrc=00, hold until mem_ready=1, then go to MEMWB.
REQ-023 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-024 MEMWRITE SHALL drive mem_req=1, AdrSrc=1, ResultSrc=00 and MemWrite=1, hold until mem_ready=1, then go to FETCH.
REQ-025 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp funct; EXECI SHALL drive the same but with ALUSrcB=01; both SHALL go to ALUWB.
REQ-026 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-027 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-028 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp sub, ResultSrc=00 and PCWrite=zero_flg, then go to FETCH.
REQ-029 ILLEGAL SHALL drive halted=1 and every write enable and mem_req to 0, and SHALL be left only by rst.
REQ-030 The ALU decoder SHALL map ALUOp add -> 000 and sub -> 001; for ALUOp funct it SHALL decode funct3: 000 -> SUB only when opcode[5]=1 and funct7[5]=1, else ADD; 010 -> SLT; 110 -> OR; 111 -> AND; any other funct3 -> ADD.
REQ-031 ImmSrc SHALL be decoded combinationally from the opcode in every state: load and I-type -> 00, store -> 01, branch -> 10, JAL -> 11, otherwise 00.
REQ-032 instr_retired SHALL pulse for exactly one cycle in MEMWB, in ALUWB, in BEQ, and in MEMWRITE in the cycle mem_ready=1.
REQ-033 Latency with mem_ready always 1 SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
REQ-034 mem_ready asserted in any state other than FETCH, MEMREAD or MEMWRITE SHALL be ignored.
REQ-035 Any value of mem_req, MemWrite or IRWrite SHALL NOT be driven outside the states listed above.

Reset
REQ-036 While rst=1, state SHALL load FETCH and all outputs SHALL be 0, including mem_req, ResultSrc, ALU selects and halted.
REQ-037 On the first cycle after rst falls, the block SHALL be in FETCH with mem_req=1.
REQ-038 An rst asserted mid-instruction, including during a memory wait, SHALL abort the instruction with no further write enables and return to FETCH on the next edge.

Verification
REQ-039 add x1,x2,x3 (0x003100B3), mem_ready=1 -> states 0,1,6,7; RegWrite=1 in cycle 4; ALUControl=000; instr_retired in cycle 4.
REQ-040 lw with mem_ready low for 3 cycles in MEMREAD -> state remains 3 for 3 cycles; MEMWB follows; total latency 8 cycles.
REQ-041 beq with zero_flg=1, then again with zero_flg=0 -> PCWrite=1 in BEQ for the first; PCWrite=0 for the second; both take 3 cycles.
REQ-042 sub (funct7=0100000) and addi with imm[10]=1 -> ALUControl=001 for sub; ALUControl=000 for addi.
REQ-043 Opcode 0x7F with HALT_ON_ILLEGAL=1 -> state=11, halted=1, no enables asserted for 20 cycles; rst clears halted.
REQ-044 rst pulsed during MEMWRITE wait -> MemWrite=0 from the reset cycle on; state=0 afterwards.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V subset control unit (lw, sw, R-type, I-type ALU, jal, beq).
// A Moore-style FSM sequences each instruction through FETCH/DECODE and a
// class-specific tail. Control outputs are decoded from the state register;
// only IRWrite/PCWrite in FETCH, PCWrite in BEQ and instr_retired in MEMWRITE
// follow the current-cycle handshake/flag inputs.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   instruction     : instruction register contents (valid from DECODE on)
//   zero_flg        : ALU zero result, used by BEQ
//   mem_ready       : memory access completes this cycle
//   mem_req, AdrSrc : memory request and address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite, MemWrite, RegWrite : write enables
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc : datapath selects
//   instr_retired   : one-cycle pulse when an instruction completes
//   halted          : sticky illegal-opcode indication
//   state           : debug view of the state register
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        zero_flg,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic        instr_retired,
    output logic        halted,
    output logic [3:0]  state
);

    localparam int unsigned OPW = 7;

    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPW-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    state_e         state_q, state_d;
    aluop_e         alu_op;
    logic [OPW-1:0] opcode;
    logic [2:0]     funct3;
    logic           funct7_5;
    logic           unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign funct3            = instruction[14:12];
    assign funct7_5          = instruction[30];
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state control decode; rst forces every output low in the same cycle
    // so an aborted instruction issues no further enables.
    always_comb begin
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        instr_retired = 1'b0;
        halted        = 1'b0;
        alu_op        = ALUOP_ADD;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc     = 2'b01;
                    RegWrite      = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req       = 1'b1;
                    AdrSrc        = 1'b1;
                    MemWrite      = 1'b1;
                    instr_retired = mem_ready;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    alu_op  = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite      = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA       = 2'b10;
                    alu_op        = ALUOP_SUB;
                    PCWrite       = zero_flg;
                    instr_retired = 1'b1;
                end
                S_ILLEGAL: halted = 1'b1;
                default: ;
            endcase
        end
    end

    // ALU decoder; SUB only for R-type (opcode[5]) with funct7[5] set, so
    // addi with imm[10]=1 still adds.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALUOP_ADD: ALUControl = 3'b000;
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (opcode[5] && funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format from opcode, independent of state
    always_comb begin
        ImmSrc = 2'b00;
        if (!rst) begin
            case (opcode)
                OP_STORE:  ImmSrc = 2'b01;
                OP_BRANCH: ImmSrc = 2'b10;
                OP_JAL:    ImmSrc = 2'b11;
                default:   ImmSrc = 2'b00;
            endcase
        end
    end

    assign state = rst ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences with literal
// expectations, then randomized instruction/handshake/reset traffic checked
// each cycle against an instruction-level phase model.
module tb_multicycle_controller;

    localparam bit HALT = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        zero_flg = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic        instr_retired, halted;
    logic [3:0]  state;

    multicycle_controller #(.HALT_ON_ILLEGAL(HALT)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero_flg(zero_flg),
        .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .instr_retired(instr_retired), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
        logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
        logic [2:0] ALUControl;
        logic [1:0] ImmSrc;
        logic       instr_retired, halted;
        logic [3:0] state;
    } ctl_t;

    // Model: the phase list of the instruction in flight and our position in it
    int m_seq[8];
    int m_len = 2;
    int m_pos = 0;
    initial begin
        m_seq[0] = 0;
        m_seq[1] = 1;
    end

    function automatic logic [1:0] imm_exp(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // kind: 0 add, 1 sub, 2 funct
    function automatic logic [2:0] alu_exp(input int kind, input logic [31:0] ins);
        int f3;
        if (kind == 0) return 3'd0;
        if (kind == 1) return 3'd1;
        f3 = int'(ins[14:12]);
        if (f3 == 2) return 3'd5;
        if (f3 == 6) return 3'd3;
        if (f3 == 7) return 3'd2;
        if (f3 == 0 && ins[5] && ins[30]) return 3'd1;
        return 3'd0;
    endfunction

    function automatic ctl_t model_out(input int st, input logic [31:0] ins,
                                       input logic zf, input logic mr, input logic r);
        ctl_t c;
        int   kind;
        c = '0;
        kind = 0;
        if (r) return c;
        c.state  = 4'(st);
        c.ImmSrc = imm_exp(ins[6:0]);
        case (st)
            0:  begin c.mem_req = 1; c.ALUSrcB = 2; c.ResultSrc = 2; c.IRWrite = mr; c.PCWrite = mr; end
            1:  begin c.ALUSrcA = 1; c.ALUSrcB = 1; end
            2:  begin c.ALUSrcA = 2; c.ALUSrcB = 1; end
            3:  begin c.mem_req = 1; c.AdrSrc = 1; end
            4:  begin c.ResultSrc = 1; c.RegWrite = 1; c.instr_retired = 1; end
            5:  begin c.mem_req = 1; c.AdrSrc = 1; c.MemWrite = 1; c.instr_retired = mr; end
            6:  begin c.ALUSrcA = 2; kind = 2; end
            7:  begin c.RegWrite = 1; c.instr_retired = 1; end
            8:  begin c.ALUSrcA = 2; c.ALUSrcB = 1; kind = 2; end
            9:  begin c.ALUSrcA = 1; c.ALUSrcB = 2; c.PCWrite = 1; end
            10: begin c.ALUSrcA = 2; kind = 1; c.PCWrite = zf; c.instr_retired = 1; end
            11: c.halted = 1;
            default: ;
        endcase
        c.ALUControl = alu_exp(kind, ins);
        return c;
    endfunction

    // Compare every cycle, then advance the model to the next cycle
    always @(negedge clk) begin : compare
        ctl_t e, a;
        int   cur;
        cur = m_seq[m_pos];
        e = model_out(cur, instruction, zero_flg, mem_ready, rst);
        a = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_retired, halted, state};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t model_state=%0d got=%h want=%h", $time, cur, a, e);
        end
        if (rst) begin
            m_len = 2; m_pos = 0;
        end else if (cur == 11) begin
            m_pos = m_pos;
        end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
            m_pos = m_pos;
        end else if (m_pos == 1) begin
            m_len = 2;
            case (instruction[6:0])
                7'b0000011: begin m_seq[2] = 2; m_seq[3] = 3; m_seq[4] = 4; m_len = 5; end
                7'b0100011: begin m_seq[2] = 2; m_seq[3] = 5; m_len = 4; end
                7'b0110011: begin m_seq[2] = 6; m_seq[3] = 7; m_len = 4; end
                7'b0010011: begin m_seq[2] = 8; m_seq[3] = 7; m_len = 4; end
                7'b1101111: begin m_seq[2] = 9; m_seq[3] = 7; m_len = 4; end
                7'b1100011: begin m_seq[2] = 10; m_len = 3; end
                default: if (HALT) begin m_seq[2] = 11; m_len = 3; end
            endcase
            m_pos = (m_len == 2) ? 0 : 2;
        end else if (m_pos == m_len - 1) begin
            m_len = 2; m_pos = 0;
        end else begin
            m_pos++;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [31:0] ins, input logic zf, input logic mr);
        @(posedge clk);
        #1;
        rst = r; instruction = ins; zero_flg = zf; mem_ready = mr;
        @(negedge clk);
        #1;
    endtask

    logic       rw_h[16], ir_h[16], pcw_h[16], mw_h[16];
    logic [2:0] alu_h[16];

    // es holds the expected state of cycle i in nibble i; mrv bit i is mem_ready
    task automatic seq_chk(input string nm, input logic [31:0] ins, input logic zf,
                           input int n, input logic [63:0] es, input logic [15:0] mrv);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, ins, zf, mrv[i]);
            chk($sformatf("%s_state%0d", nm, i), int'(state), int'(es[4*i +: 4]));
            rw_h[i] = RegWrite; ir_h[i] = instr_retired; pcw_h[i] = PCWrite;
            mw_h[i] = MemWrite; alu_h[i] = ALUControl;
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        int          k;
        w = $urandom;
        k = int'($urandom_range(0, 13));
        case (k)
            0, 1:    op = 7'b0000011;
            2, 3:    op = 7'b0100011;
            4, 5, 6: op = 7'b0110011;
            7, 8, 9: op = 7'b0010011;
            10:      op = 7'b1101111;
            11, 12:  op = 7'b1100011;
            default: begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end
        endcase
        w[6:0] = op;
        return w;
    endfunction

    initial begin : stim
        int halt_cnt, halt_lim;
        logic [31:0] cur_ins;
        logic r;

        // Reset: everything low, state reads FETCH
        tick(1'b1, 32'h003100B3, 1'b0, 1'b1);
        tick(1'b1, 32'h003100B3, 1'b0, 1'b1);
        chk("rst_state", int'(state), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_resultsrc", int'(ResultSrc), 0);
        chk("rst_alusrcb", int'(ALUSrcB), 0);

        // add x1,x2,x3: 0,1,6,7; first cycle after reset is FETCH with mem_req
        tick(1'b0, 32'h003100B3, 1'b0, 1'b1);
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_mem_req", int'(mem_req), 1);
        seq_chk("add", 32'h003100B3, 1'b0, 3, 64'h761, 16'hFFFF);
        chk("add_alu", int'(alu_h[1]), 0);
        chk("add_regwrite_c4", int'(rw_h[2]), 1);
        chk("add_retired_c4", int'(ir_h[2]), 1);

        // lw with three wait cycles in MEMREAD: 8 cycles total
        seq_chk("lw", 32'h00012083, 1'b0, 8, 64'h43333210, 16'hFFC7);
        chk("lw_regwrite", int'(rw_h[7]), 1);
        chk("lw_retired", int'(ir_h[7]), 1);

        // beq taken then not taken, 3 cycles each
        seq_chk("beq_t", 32'h00000063, 1'b1, 3, 64'hA10, 16'hFFFF);
        chk("beq_t_pcwrite", int'(pcw_h[2]), 1);
        chk("beq_t_retired", int'(ir_h[2]), 1);
        seq_chk("beq_n", 32'h00000063, 1'b0, 3, 64'hA10, 16'hFFFF);
        chk("beq_n_pcwrite", int'(pcw_h[2]), 0);

        // sub uses SUB; addi with imm[10]=1 still ADD
        seq_chk("sub", 32'h403100B3, 1'b0, 4, 64'h7610, 16'hFFFF);
        chk("sub_alu", int'(alu_h[2]), 1);
        seq_chk("addi", 32'h40010093, 1'b0, 4, 64'h7810, 16'hFFFF);
        chk("addi_alu", int'(alu_h[2]), 0);

        // sw and jal, 4 cycles each
        seq_chk("sw", 32'h00112023, 1'b0, 4, 64'h5210, 16'hFFFF);
        chk("sw_memwrite", int'(mw_h[3]), 1);
        chk("sw_retired", int'(ir_h[3]), 1);
        seq_chk("jal", 32'h0000006F, 1'b0, 4, 64'h7910, 16'hFFFF);
        chk("jal_pcwrite", int'(pcw_h[2]), 1);

        // Reset during MEMWRITE wait aborts the store
        seq_chk("sw_abort", 32'h00112023, 1'b0, 4, 64'h5210, 16'hFFF7);
        chk("sw_abort_memwrite_before", int'(MemWrite), 1);
        tick(1'b1, 32'h00112023, 1'b0, 1'b0);
        chk("sw_abort_memwrite_rst", int'(MemWrite), 0);
        chk("sw_abort_state_rst", int'(state), 0);
        tick(1'b0, 32'h00112023, 1'b0, 1'b0);
        chk("sw_abort_state_after", int'(state), 0);
        chk("sw_abort_memwrite_after", int'(MemWrite), 0);
        chk("sw_abort_mem_req_after", int'(mem_req), 1);

        // Illegal opcode halts with no enables until reset
        seq_chk("ill", 32'h0000007F, 1'b0, 2, 64'h10, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 32'h0000007F, 1'b1, 1'b1);
            chk("ill_state", int'(state), 11);
            chk("ill_halted", int'(halted), 1);
            chk("ill_enables", int'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite, instr_retired}), 0);
        end
        tick(1'b1, 32'h0000007F, 1'b0, 1'b1);
        chk("ill_rst_halted", int'(halted), 0);
        tick(1'b0, 32'h0000007F, 1'b0, 1'b0);
        chk("ill_after_state", int'(state), 0);
        chk("ill_after_halted", int'(halted), 0);

        // Randomized traffic against the model
        halt_cnt = 0;
        halt_lim = 10;
        cur_ins  = 32'h003100B3;
        for (int c = 0; c < 4000; c++) begin
            r = 1'b0;
            if (m_seq[m_pos] == 11) begin
                halt_cnt++;
                if (halt_cnt == 1) halt_lim = int'($urandom_range(3, 20));
                if (halt_cnt >= halt_lim) r = 1'b1;
            end else if ($urandom_range(0, 60) == 0) begin
                r = 1'b1;
            end
            if (r) halt_cnt = 0;
            if (m_seq[m_pos] == 0) cur_ins = rand_instr();
            tick(r, cur_ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
